fanout_repeater_fork: RTL and testbench

// - Parametrised elastic fanout: one driver word is broadcast to N_LOADS load branches, each a valid/ready

---
 rtl/fanout_pkg.sv | 28 ++
 rtl/fanout_branch.sv | 65 ++++++
 rtl/fanout_repeater_fork.sv | 77 +++++++
 tb/tb_fanout_repeater_fork.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanout_pkg.sv
// ============================================================================
//  Module : fanout_pkg
//  Shared defaults, fork-state types and slicing helper for the fanout fork.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package fanout_pkg;

    localparam int DEF_WIDTH   = 1;
    localparam int DEF_N_LOADS = 4;
    localparam int DEF_STAGES  = 2;
    localparam int MAX_LOADS   = 64;

    typedef logic [MAX_LOADS-1:0] served_mask_t;

    typedef struct packed {
        served_mask_t served;
    } fork_state_t;

    // Low bit index of branch idx inside a flattened per-branch bus.
    function automatic int branch_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fanout_branch.sv
// ============================================================================
//  Module : fanout_branch
//  STAGES-deep valid/ready repeater chain feeding one load.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module fanout_branch
    import fanout_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES:0]   w_adv;

    // A stage may load when it is empty or its content moves on this cycle.
    assign w_adv[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign w_adv[k] = !r_valid[k] || w_adv[k+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= in_data;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_data[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fanout_repeater_fork.sv
// ============================================================================
//  Module : fanout_repeater_fork
//  Eager elastic fork of one driver word onto N_LOADS repeater branches.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module fanout_repeater_fork
    import fanout_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_LOADS = DEF_N_LOADS,
    parameter int STAGES  = DEF_STAGES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     drv_valid,
    input  logic [WIDTH-1:0]         drv_data,
    output logic                     drv_ready,
    input  logic                     tie_lo,
    input  logic [N_LOADS-1:0]       load_en,
    output logic [N_LOADS-1:0]       load_valid,
    output logic [N_LOADS*WIDTH-1:0] load_data,
    input  logic [N_LOADS-1:0]       load_ready,
    output logic [WIDTH-1:0]         tap_data
);

    logic [WIDTH-1:0]   w_fork_data;
    logic [N_LOADS-1:0] r_served;
    logic [N_LOADS-1:0] w_take;
    logic [N_LOADS-1:0] w_done;
    logic [N_LOADS-1:0] w_br_ready;
    logic               w_live;
    logic               w_accept;

    assign w_fork_data = tie_lo ? '0 : drv_data;
    assign tap_data    = w_fork_data;

    // Disabled branches count as done, so an all-zero mask simply drops words.
    assign w_live   = drv_valid && !rst;
    assign w_take   = {N_LOADS{w_live}} & load_en & ~r_served & w_br_ready;
    assign w_done   = ~load_en | w_take | r_served;
    assign w_accept = w_live && (&w_done);

    assign drv_ready = w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_served <= '0;
        end else if (w_accept) begin
            r_served <= '0;
        end else begin
            r_served <= r_served | w_take;
        end
    end

    for (genvar i = 0; i < N_LOADS; i++) begin : g_branch
        localparam int LO = branch_lo(i, WIDTH);

        fanout_branch #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES)
        ) u_branch (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (w_take[i]),
            .in_data   (w_fork_data),
            .in_ready  (w_br_ready[i]),
            .out_valid (load_valid[i]),
            .out_data  (load_data[LO +: WIDTH]),
            .out_ready (load_ready[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_fanout_repeater_fork.sv
// ============================================================================
//  Module : tb_fanout_repeater_fork
//  Self-checking bench: vector table plus scoreboarded multi-cycle sequences.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fanout_repeater_fork;

    localparam int WIDTH   = 8;
    localparam int N_LOADS = 4;
    localparam int STAGES  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     drv_valid;
    logic [WIDTH-1:0]         drv_data;
    logic                     drv_ready;
    logic                     tie_lo;
    logic [N_LOADS-1:0]       load_en;
    logic [N_LOADS-1:0]       load_valid;
    logic [N_LOADS*WIDTH-1:0] load_data;
    logic [N_LOADS-1:0]       load_ready;
    logic [WIDTH-1:0]         tap_data;

    fanout_repeater_fork #(
        .WIDTH   (WIDTH),
        .N_LOADS (N_LOADS),
        .STAGES  (STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drv_valid  (drv_valid),
        .drv_data   (drv_data),
        .drv_ready  (drv_ready),
        .tie_lo     (tie_lo),
        .load_en    (load_en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .tap_data   (tap_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;
    logic [WIDTH-1:0] exp_q [N_LOADS][$];

    typedef struct {
        logic             dv;
        logic             tie;
        logic [3:0]       en;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] exp_tap;
        logic             exp_rdy;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        for (int i = 0; i < N_LOADS; i++) begin
            if (load_en[i]) exp_q[i].push_back(tie_lo ? '0 : d);
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        int n;
        drv_data  = d;
        drv_valid = 1'b1;
        push_word(d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!drv_ready && n < 200);
        if (!drv_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0h never accepted", d);
        end else begin
            accepts++;
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        int pend;
        n = 0;
        do begin
            @(negedge clk);
            pend = 0;
            for (int i = 0; i < N_LOADS; i++) pend += exp_q[i].size();
            n++;
        end while (pend != 0 && n < 100);
        if (pend != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding", pend);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N_LOADS; i++) begin
                    if (load_valid[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL b%0d_unexpected: got %0h expected no word", i,
                                     load_data[i*WIDTH +: WIDTH]);
                        end else if (load_ready[i]) begin
                            check($sformatf("b%0d_data", i), 32'(load_data[i*WIDTH +: WIDTH]),
                                  32'(exp_q[i].pop_front()));
                        end else begin
                            check($sformatf("b%0d_hold", i), 32'(load_data[i*WIDTH +: WIDTH]),
                                  32'(exp_q[i][0]));
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int start;
        vecs[0] = '{1'b1, 1'b0, 4'hF, 8'h11, 8'h11, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 4'hF, 8'h3C, 8'h3C, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 4'hF, 8'h77, 8'h77, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 4'hF, 8'hFF, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 4'hF, 8'h5A, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'h0, 8'h42, 8'h42, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 4'h0, 8'h99, 8'h99, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 4'h5, 8'hC3, 8'hC3, 1'b1};

        rst        = 1'b1;
        drv_valid  = 1'b0;
        drv_data   = '0;
        tie_lo     = 1'b0;
        load_en    = 4'hF;
        load_ready = 4'hF;

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1);
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        drv_valid = 1'b1;
        #1;
        check("rst_load_valid", 32'(load_valid), 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_drv_ready", 32'(drv_ready), 32'h0);
        drv_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table, all branches empty and ready
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            #1;
            drv_valid = vecs[v].dv;
            tie_lo    = vecs[v].tie;
            load_en   = vecs[v].en;
            drv_data  = vecs[v].data;
            #1;
            check($sformatf("vec%0d_tap", v), 32'(tap_data), 32'(vecs[v].exp_tap));
            check($sformatf("vec%0d_ready", v), 32'(drv_ready), 32'(vecs[v].exp_rdy));
            if (vecs[v].dv && drv_ready) begin
                for (int i = 0; i < N_LOADS; i++) begin
                    if (vecs[v].en[i]) exp_q[i].push_back(vecs[v].exp_tap);
                end
            end
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        tie_lo    = 1'b0;
        load_en   = 4'hF;
        drain();

        // Streaming 0..15 at one word per cycle
        @(posedge clk);
        #1;
        start = cyc;
        for (int w = 0; w < 16; w++) send_word(8'(w));
        check("stream_cycles", 32'(cyc - start), 32'd16);
        drain();

        // Partial stall on branch 2
        @(posedge clk);
        #1;
        load_ready = 4'b1011;
        accepts    = 0;
        fork
            for (int w = 0; w < 6; w++) send_word(8'h20 + 8'(w));
            begin
                repeat (6) @(posedge clk);
                #2;
                check("stall_accepts", 32'(accepts), 32'd2);
                check("stall_drv_ready", 32'(drv_ready), 32'h0);
                load_ready = 4'hF;
            end
        join
        drain();

        // Masking
        @(posedge clk);
        #1;
        load_en = 4'b0101;
        for (int w = 0; w < 4; w++) send_word(8'h40 + 8'(w));
        drain();
        load_en   = 4'h0;
        drv_data  = 8'h55;
        drv_valid = 1'b1;
        #1;
        check("mask0_ready_hi", 32'(drv_ready), 32'h1);
        repeat (4) @(posedge clk);
        #1;
        drv_valid = 1'b0;
        #1;
        check("mask0_ready_lo", 32'(drv_ready), 32'h0);
        repeat (3) @(negedge clk);
        check("mask0_no_valid", 32'(load_valid), 32'h0);

        // Mid-flight disable of branch 1
        @(posedge clk);
        #1;
        load_en    = 4'hF;
        load_ready = 4'b1101;
        send_word(8'h61);
        send_word(8'h62);
        load_en = 4'b1101;
        send_word(8'h63);
        repeat (2) @(negedge clk);
        check("disable_hold", 32'(load_valid[1]), 32'h1);
        @(posedge clk);
        #1;
        load_ready = 4'hF;
        drain();
        repeat (3) @(negedge clk);
        check("disable_empty", 32'(load_valid), 32'h0);

        // Reset mid-stream with words in flight
        @(posedge clk);
        #1;
        load_en    = 4'hF;
        load_ready = 4'h0;
        send_word(8'hB1);
        send_word(8'hB2);
        drv_data  = 8'hB3;
        drv_valid = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_load_valid", 32'(load_valid), 32'h0);
        check("midrst_drv_ready", 32'(drv_ready), 32'h0);
        for (int i = 0; i < N_LOADS; i++) exp_q[i].delete();
        drv_valid  = 1'b0;
        load_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_no_pulse0", 32'(load_valid), 32'h0);
        @(negedge clk);
        check("release_no_pulse1", 32'(load_valid), 32'h0);
        @(posedge clk);
        #1;
        drv_data  = 8'hA5;
        drv_valid = 1'b1;
        push_word(8'hA5);
        @(negedge clk);
        check("a5_accept", 32'(drv_ready), 32'h1);
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        @(negedge clk);
        check("a5_lat1", 32'(load_valid), 32'h0);
        @(negedge clk);
        check("a5_lat2", 32'(load_valid), 32'hF);
        drain();

        for (int i = 0; i < N_LOADS; i++) begin
            check($sformatf("b%0d_q_empty", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
